// File: rtl/instruction_decode.sv
// MIPS decode stage: owns the 32x32 register file, decodes the fetched instruction
// and issues a registered control/operand bundle to the ALU with a one-cycle stage3 strobe.
module instruction_decode #(
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [31:0]        instr,
    input  logic               stage2,
    input  logic               wbEnable,
    input  logic [4:0]         wbAddr,
    input  logic [31:0]        wbData,
    output logic               stage3,
    output logic [31:0]        rsValue,
    output logic [31:0]        rtValue,
    output logic [31:0]        immExt,
    output logic [4:0]         destReg,
    output logic [3:0]         aluOp,
    output logic               aluSrc,
    output logic               memRead,
    output logic               memWrite,
    output logic               regWrite,
    output logic               memToReg,
    output logic               branch,
    output logic               jump,
    output logic               illegal,
    output logic [25:0]        jumpTarget,
    output logic [COUNT_W-1:0] decodedCount
);
    typedef enum logic {IDLE, ISSUE} state_t;

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  dest;
        logic [3:0]  aluop;
        logic        alusrc;
        logic        memrd;
        logic        memwr;
        logic        regwr;
        logic        mem2reg;
        logic        branch;
        logic        jump;
        logic        illegal;
        logic [25:0] jt;
    } dec_t;

    state_t      state;
    logic [31:0] rf [32];
    dec_t        d;
    logic [31:0] rs_rd, rt_rd;

    wire [5:0]  op    = instr[31:26];
    wire [4:0]  rs    = instr[25:21];
    wire [4:0]  rt    = instr[20:16];
    wire [4:0]  rd    = instr[15:11];
    wire [4:0]  shamt = instr[10:6];
    wire [5:0]  funct = instr[5:0];
    wire [31:0] sext  = {{16{instr[15]}}, instr[15:0]};
    wire [31:0] zext  = {16'b0, instr[15:0]};

    assign stage3 = (state == ISSUE);

    always_comb begin
        d = '0;
        case (op)
            6'h00: begin
                d.dest  = rd;
                d.regwr = 1'b1;
                case (funct)
                    6'h20: d.aluop = 4'd0;
                    6'h22: d.aluop = 4'd1;
                    6'h24: d.aluop = 4'd2;
                    6'h25: d.aluop = 4'd3;
                    6'h2A: d.aluop = 4'd4;
                    6'h00: begin d.aluop = 4'd5; d.alusrc = 1'b1; d.imm = {27'b0, shamt}; end
                    6'h02: begin d.aluop = 4'd6; d.alusrc = 1'b1; d.imm = {27'b0, shamt}; end
                    default: begin d = '0; d.illegal = 1'b1; end
                endcase
            end
            6'h08: begin d.aluop = 4'd0; d.imm = sext; d.alusrc = 1'b1; d.dest = rt; d.regwr = 1'b1; end
            6'h0C: begin d.aluop = 4'd2; d.imm = zext; d.alusrc = 1'b1; d.dest = rt; d.regwr = 1'b1; end
            6'h0D: begin d.aluop = 4'd3; d.imm = zext; d.alusrc = 1'b1; d.dest = rt; d.regwr = 1'b1; end
            6'h23: begin
                d.aluop = 4'd0; d.imm = sext; d.alusrc = 1'b1; d.dest = rt;
                d.regwr = 1'b1; d.memrd = 1'b1; d.mem2reg = 1'b1;
            end
            6'h2B: begin d.aluop = 4'd0; d.imm = sext; d.alusrc = 1'b1; d.memwr = 1'b1; end
            6'h04: begin d.aluop = 4'd1; d.imm = sext; d.branch = 1'b1; end
            6'h02: begin d.jump = 1'b1; d.jt = instr[25:0]; end
            default: d.illegal = 1'b1;
        endcase
        // writes to $0 are meaningless, so 0x00000000 becomes a true NOP
        if (d.dest == 5'd0) d.regwr = 1'b0;
    end

    // same-edge writeback wins over the stale array value
    always_comb begin
        rs_rd = rf[rs];
        rt_rd = rf[rt];
        if (wbEnable && wbAddr == rs) rs_rd = wbData;
        if (wbEnable && wbAddr == rt) rt_rd = wbData;
        if (rs == 5'd0) rs_rd = '0;
        if (rt == 5'd0) rt_rd = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
            rsValue      <= '0;
            rtValue      <= '0;
            immExt       <= '0;
            destReg      <= '0;
            aluOp        <= '0;
            aluSrc       <= 1'b0;
            memRead      <= 1'b0;
            memWrite     <= 1'b0;
            regWrite     <= 1'b0;
            memToReg     <= 1'b0;
            branch       <= 1'b0;
            jump         <= 1'b0;
            illegal      <= 1'b0;
            jumpTarget   <= '0;
            decodedCount <= '0;
        end else begin
            if (wbEnable && wbAddr != 5'd0) rf[wbAddr] <= wbData;
            case (state)
                IDLE:    if (stage2) state <= ISSUE;
                ISSUE:   if (!stage2) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (stage2) begin
                rsValue      <= rs_rd;
                rtValue      <= rt_rd;
                immExt       <= d.imm;
                destReg      <= d.dest;
                aluOp        <= d.aluop;
                aluSrc       <= d.alusrc;
                memRead      <= d.memrd;
                memWrite     <= d.memwr;
                regWrite     <= d.regwr;
                memToReg     <= d.mem2reg;
                branch       <= d.branch;
                jump         <= d.jump;
                illegal      <= d.illegal;
                jumpTarget   <= d.jt;
                decodedCount <= decodedCount + COUNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode: a spec-level model queues expected bundles
// at each capture; a negedge monitor compares issues and checks that outputs hold when idle.
module tb_instruction_decode;
    logic        clock = 0;
    logic        reset_n = 0;
    logic [31:0] instr = 0;
    logic        stage2 = 0;
    logic        wbEnable = 0;
    logic [4:0]  wbAddr = 0;
    logic [31:0] wbData = 0;

    logic        stage3, aluSrc, memRead, memWrite, regWrite, memToReg, branch, jump, illegal;
    logic [31:0] rsValue, rtValue, immExt;
    logic [4:0]  destReg;
    logic [3:0]  aluOp;
    logic [25:0] jumpTarget;
    logic [15:0] decodedCount;

    logic        b_stage3, b_aluSrc, b_memRead, b_memWrite, b_regWrite, b_memToReg, b_branch, b_jump, b_illegal;
    logic [31:0] b_rsValue, b_rtValue, b_immExt;
    logic [4:0]  b_destReg;
    logic [3:0]  b_aluOp;
    logic [25:0] b_jumpTarget;
    logic [1:0]  b_decodedCount;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    instruction_decode #(.COUNT_W(16)) u1 (
        .clock(clock), .reset_n(reset_n), .instr(instr), .stage2(stage2),
        .wbEnable(wbEnable), .wbAddr(wbAddr), .wbData(wbData),
        .stage3(stage3), .rsValue(rsValue), .rtValue(rtValue), .immExt(immExt),
        .destReg(destReg), .aluOp(aluOp), .aluSrc(aluSrc), .memRead(memRead),
        .memWrite(memWrite), .regWrite(regWrite), .memToReg(memToReg), .branch(branch),
        .jump(jump), .illegal(illegal), .jumpTarget(jumpTarget), .decodedCount(decodedCount)
    );

    instruction_decode #(.COUNT_W(2)) u2 (
        .clock(clock), .reset_n(reset_n), .instr(instr), .stage2(stage2),
        .wbEnable(wbEnable), .wbAddr(wbAddr), .wbData(wbData),
        .stage3(b_stage3), .rsValue(b_rsValue), .rtValue(b_rtValue), .immExt(b_immExt),
        .destReg(b_destReg), .aluOp(b_aluOp), .aluSrc(b_aluSrc), .memRead(b_memRead),
        .memWrite(b_memWrite), .regWrite(b_regWrite), .memToReg(b_memToReg), .branch(b_branch),
        .jump(b_jump), .illegal(b_illegal), .jumpTarget(b_jumpTarget), .decodedCount(b_decodedCount)
    );

    typedef struct packed {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [4:0]  dest;
        logic [3:0]  aluop;
        logic [7:0]  ctl;   // {aluSrc,memRead,memWrite,regWrite,memToReg,branch,jump,illegal}
        logic [25:0] jt;
        logic [31:0] cnt;
    } exp_t;

    exp_t        q[$];
    exp_t        last = '0;
    logic [31:0] regs [32];
    logic [31:0] cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] i);
        exp_t       e;
        logic [5:0] op, fn;
        bit         isr, known, shift, itype_rt;
        logic       alusrc, memrd, memwr, regwr, mem2reg, br, jmp;
        e  = '0;
        op = i[31:26];
        fn = i[5:0];
        isr   = (op == 6'h00) && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02});
        known = isr || (op inside {6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02});
        if (!known) begin
            e.ctl = 8'h01;
            return e;
        end
        shift    = isr && (fn inside {6'h00, 6'h02});
        itype_rt = op inside {6'h08, 6'h0C, 6'h0D, 6'h23};
        if (isr) e.aluop = (fn == 6'h20) ? 4'd0 : (fn == 6'h22) ? 4'd1 : (fn == 6'h24) ? 4'd2 :
                           (fn == 6'h25) ? 4'd3 : (fn == 6'h2A) ? 4'd4 : (fn == 6'h00) ? 4'd5 : 4'd6;
        else     e.aluop = (op == 6'h0C) ? 4'd2 : (op == 6'h0D) ? 4'd3 : (op == 6'h04) ? 4'd1 : 4'd0;
        e.dest = isr ? i[15:11] : itype_rt ? i[20:16] : 5'd0;
        if (shift)                               e.imm = {27'b0, i[10:6]};
        else if (op inside {6'h0C, 6'h0D})        e.imm = {16'b0, i[15:0]};
        else if (!isr && op != 6'h02)             e.imm = {{16{i[15]}}, i[15:0]};
        alusrc  = shift || itype_rt || op == 6'h2B;
        memrd   = op == 6'h23;
        memwr   = op == 6'h2B;
        mem2reg = op == 6'h23;
        br      = op == 6'h04;
        jmp     = op == 6'h02;
        regwr   = (isr || itype_rt) && e.dest != 5'd0;
        e.ctl   = {alusrc, memrd, memwr, regwr, mem2reg, br, jmp, 1'b0};
        e.jt    = jmp ? i[25:0] : 26'd0;
        return e;
    endfunction

    function automatic logic [31:0] rdreg(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wbEnable && wbAddr == a) return wbData;
        return regs[a];
    endfunction

    // reference model, sampled on the capture edge
    always @(posedge clock) begin
        exp_t e;
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) regs[i] = 0;
            q.delete();
            cnt = 0;
        end else begin
            if (stage2) begin
                e     = ref_decode(instr);
                e.rs  = rdreg(instr[25:21]);
                e.rt  = rdreg(instr[20:16]);
                cnt   = cnt + 1;
                e.cnt = cnt;
                q.push_back(e);
            end
            if (wbEnable && wbAddr != 0) regs[wbAddr] = wbData;
        end
    end

    task automatic cmp(input exp_t e, input logic s3);
        chk("stage3",   {63'b0, stage3}, {63'b0, s3});
        chk("stage3_b", {63'b0, b_stage3}, {63'b0, s3});
        chk("rsValue",  {32'b0, rsValue}, {32'b0, e.rs});
        chk("rtValue",  {32'b0, rtValue}, {32'b0, e.rt});
        chk("immExt",   {32'b0, immExt}, {32'b0, e.imm});
        chk("destReg",  {59'b0, destReg}, {59'b0, e.dest});
        chk("aluOp",    {60'b0, aluOp}, {60'b0, e.aluop});
        chk("ctl",      {56'b0, aluSrc, memRead, memWrite, regWrite, memToReg, branch, jump, illegal},
                        {56'b0, e.ctl});
        chk("jumpTarget", {38'b0, jumpTarget}, {38'b0, e.jt});
        chk("count16",  {48'b0, decodedCount}, {48'b0, e.cnt[15:0]});
        chk("count2",   {62'b0, b_decodedCount}, {62'b0, e.cnt[1:0]});
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            last = '0;
            q.delete();
            cmp(last, 1'b0);
        end else if (q.size() > 0) begin
            last = q.pop_front();
            cmp(last, 1'b1);
        end else begin
            cmp(last, 1'b0);
        end
    end

    task automatic cyc(input logic s2, input logic [31:0] ins, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
        stage2 = s2; instr = ins; wbEnable = we; wbAddr = wa; wbData = wd;
        @(posedge clock);
        #1;
        stage2 = 0; wbEnable = 0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  fns [7];
        logic [5:0]  ops [7];
        logic [31:0] r;
        int          k;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
        ops = '{6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02};
        r = $urandom;
        k = $urandom_range(0, 15);
        if (k < 7)       r = {6'h00, r[25:6], fns[k]};
        else if (k < 14) r = {ops[k-7], r[25:0]};
        else if (k == 15) r = 32'h0;
        return r;
    endfunction

    initial begin
        #23 reset_n = 1;
        @(posedge clock); #1;
        cyc(0, 0, 1, 5'd3, 32'h5);
        cyc(0, 0, 1, 5'd4, 32'h7);
        cyc(1, 32'h00642820, 0, 0, 0);          // add $5,$3,$4
        @(negedge clock);
        chk("add_rs", {32'b0, rsValue}, 64'd5);
        chk("add_rt", {32'b0, rtValue}, 64'd7);
        chk("add_cnt", {48'b0, decodedCount}, 64'd1);
        cyc(1, 32'h8C22FFFC, 0, 0, 0);          // lw $2,-4($1)
        @(negedge clock);
        chk("lw_imm", {32'b0, immExt}, 64'hFFFFFFFC);
        chk("lw_ctl", {59'b0, aluSrc, memRead, memToReg, 2'b0} | {59'b0, destReg}, {59'b0, 5'b11100} | 64'd2);
        cyc(1, 32'h34228000, 0, 0, 0);          // ori $2,$1,0x8000
        @(negedge clock);
        chk("ori_imm", {32'b0, immExt}, 64'h00008000);
        cyc(1, 32'h00633022, 1, 5'd3, 32'hDEADBEEF);  // sub $6,$3,$3 with bypass
        @(negedge clock);
        chk("byp_rs", {32'b0, rsValue}, 64'hDEADBEEF);
        chk("byp_rt", {32'b0, rtValue}, 64'hDEADBEEF);
        chk("sub_op", {60'b0, aluOp}, 64'd1);
        cyc(0, 0, 1, 5'd0, 32'hFFFFFFFF);
        cyc(1, 32'h00000820, 0, 0, 0);          // add $1,$0,$0
        @(negedge clock);
        chk("r0_rs", {32'b0, rsValue}, 64'd0);
        cyc(1, 32'h00000000, 0, 0, 0);
        @(negedge clock);
        chk("nop", {62'b0, regWrite, illegal}, 64'd0);
        cyc(1, 32'hFC000000, 0, 0, 0);
        @(negedge clock);
        chk("illegal", {63'b0, illegal}, 64'd1);
        // reset asserted while an issue is on the outputs
        cyc(1, 32'h00642820, 0, 0, 0);
        #2 reset_n = 0;
        #1;
        chk("rst_stage3", {63'b0, stage3}, 64'd0);
        chk("rst_cnt", {48'b0, decodedCount}, 64'd0);
        #9 reset_n = 1;
        cyc(1, 32'h00630820, 0, 0, 0);          // add $1,$3,$3 after reset
        @(negedge clock);
        chk("rst_r3", {32'b0, rsValue}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, rand_instr(), 0, 0, 0);
            @(negedge clock);
            chk("b2b_stage3", {63'b0, stage3}, 64'd1);
        end
        chk("cnt5", {48'b0, decodedCount}, 64'd5);
        chk("cnt5_w2", {62'b0, b_decodedCount}, 64'd1);
        for (int i = 0; i < 500; i++) begin
            logic [31:0] ins;
            logic [4:0]  wa;
            ins = rand_instr();
            wa  = ($urandom_range(0, 3) == 0) ? ins[25:21] : 5'($urandom);
            cyc(($urandom_range(0, 3) != 0), ins, $urandom_range(0, 1) == 1, wa, $urandom);
        end
        repeat (3) @(posedge clock);
        #1;
        chk("queue_drained", {32'b0, 32'(q.size())}, 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
